// File: rtl/predictor_pkg.sv
// Shared types and constants for the fetch-side BHT branch predictor.
package predictor_pkg;

  localparam int ADDR_W = 11;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_ZERO  = 2'b01;
  localparam logic [1:0] BR_NEG   = 2'b10;
  localparam logic [1:0] BR_CARRY = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic [1:0]        br_type;
    logic              taken;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] target;
  } q_entry_t;

  localparam int Q_ENTRY_W = $bits(q_entry_t);

  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-side and checker-side signals of the BHT predictor.
interface branch_predictor_bht_if;
  logic                             fetch_valid;
  logic [1:0]                       fetch_branch_type;
  logic [predictor_pkg::ADDR_W-1:0] fetch_addr;
  logic [predictor_pkg::ADDR_W-1:0] fetch_target;
  logic [predictor_pkg::ADDR_W-1:0] fetch_next;
  logic                             fetch_ready;
  logic                             predict_taken;
  logic [predictor_pkg::ADDR_W-1:0] predict_addr;
  logic                             chk_valid;
  logic [1:0]                       chk_branch_type;
  logic                             chk_branch_taken;
  logic [predictor_pkg::ADDR_W-1:0] chk_branch_addr;
  logic [predictor_pkg::ADDR_W-1:0] chk_jump_addr;
  logic                             res_valid;
  logic                             prediction_success;
  logic                             branch_result;
  logic                             flush;

  modport master (
    output fetch_valid, fetch_branch_type, fetch_addr, fetch_target, fetch_next,
    output res_valid, prediction_success, branch_result,
    input  fetch_ready, predict_taken, predict_addr,
    input  chk_valid, chk_branch_type, chk_branch_taken, chk_branch_addr, chk_jump_addr,
    input  flush
  );

  modport slave (
    input  fetch_valid, fetch_branch_type, fetch_addr, fetch_target, fetch_next,
    input  res_valid, prediction_success, branch_result,
    output fetch_ready, predict_taken, predict_addr,
    output chk_valid, chk_branch_type, chk_branch_taken, chk_branch_addr, chk_jump_addr,
    output flush
  );
endinterface

// File: rtl/predictor_inflight_fifo.sv
// In-flight prediction queue: synchronous FIFO with clear, occupancy-based full/empty.
module predictor_inflight_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // clear wins over a same-cycle push: that entry is wrong-path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/branch_predictor_bht.sv
// 2-bit saturating-counter BHT with in-flight queue and mispredict flush.
// Optional statistics counters built only when BHT_STATS_EN is defined.
module branch_predictor_bht import predictor_pkg::*; #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = WNT,
  parameter int         Q_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_bht_if.slave  bus,
  output logic [15:0]            stat_branches,
  output logic [15:0]            stat_mispredicts
);
  localparam int N  = 2**IDX_W;
  localparam int FW = IDX_W + Q_ENTRY_W;

  logic [1:0]       cnt [N];
  logic [IDX_W-1:0] fetch_idx, head_idx;
  q_entry_t         wr_entry, head;
  logic [FW-1:0]    rd_word;
  logic             full, empty, is_branch, push, resolve, mispredict;
  logic             unused_addr_hi;

  assign fetch_idx      = bus.fetch_addr[IDX_W-1:0];
  assign unused_addr_hi = ^bus.fetch_addr[ADDR_W-1:IDX_W];
  assign is_branch      = (bus.fetch_branch_type != BR_NONE);

  // table read is combinational, so a same-cycle update is not yet visible
  assign bus.predict_taken = bus.fetch_valid & is_branch & cnt[fetch_idx][1];
  assign bus.predict_addr  = bus.predict_taken ? bus.fetch_target : bus.fetch_next;
  assign bus.fetch_ready   = ~full;

  assign push       = bus.fetch_valid & is_branch & ~full;
  assign resolve    = bus.res_valid & ~empty;
  assign mispredict = resolve & ~bus.prediction_success;

  assign wr_entry = '{br_type:   bus.fetch_branch_type,
                      taken:     bus.predict_taken,
                      next_addr: bus.fetch_next,
                      target:    bus.fetch_target};

  predictor_inflight_fifo #(.W(FW), .DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mispredict),
    .push  (push),
    .pop   (resolve),
    .wdata ({fetch_idx, wr_entry}),
    .rdata (rd_word),
    .full  (full),
    .empty (empty)
  );

  assign {head_idx, head}     = rd_word;
  assign bus.chk_valid        = ~empty;
  assign bus.chk_branch_type  = head.br_type;
  assign bus.chk_branch_taken = head.taken;
  assign bus.chk_branch_addr  = head.next_addr;
  assign bus.chk_jump_addr    = head.target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= CNT_INIT;
    end else if (resolve) begin
      cnt[head_idx] <= cnt_update(cnt[head_idx], bus.branch_result);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.flush <= 1'b0;
    else        bus.flush <= mispredict;
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && stat_branches != 16'hFFFF)       stat_branches    <= stat_branches + 16'd1;
      if (mispredict && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`else
  assign stat_branches    = 16'h0000;
  assign stat_mispredicts = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: counter training table plus queue/flush/reset sequences.
module tb_branch_predictor_bht;
  import predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stat_br, stat_mp;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor_bht_if bus();

  branch_predictor_bht dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .stat_branches    (stat_br),
    .stat_mispredicts (stat_mp)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              result;
    logic              exp_pred;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [ADDR_W-1:0] a, input logic [1:0] t);
    bus.fetch_valid       = 1'b1;
    bus.fetch_branch_type = t;
    bus.fetch_addr        = a;
    bus.fetch_next        = a + 11'h001;
    bus.fetch_target      = a + 11'h040;
    #1;
  endtask

  task automatic clr_fetch();
    bus.fetch_valid       = 1'b0;
    bus.fetch_branch_type = 2'b00;
    bus.fetch_addr        = '0;
    bus.fetch_next        = '0;
    bus.fetch_target      = '0;
  endtask

  task automatic clr_res();
    bus.res_valid          = 1'b0;
    bus.prediction_success = 1'b0;
    bus.branch_result      = 1'b0;
  endtask

  task automatic push_br(input logic [ADDR_W-1:0] a, input logic [1:0] t);
    set_fetch(a, t);
    tick();
    clr_fetch();
  endtask

  task automatic resolve(input logic result, input logic success);
    bus.res_valid          = 1'b1;
    bus.branch_result      = result;
    bus.prediction_success = success;
    tick();
    clr_res();
  endtask

  task automatic probe(input logic [ADDR_W-1:0] a, input logic exp, input string name);
    set_fetch(a, 2'b01);
    check({name, "_taken"}, 32'(bus.predict_taken), 32'(exp));
    check({name, "_addr"}, 32'(bus.predict_addr), 32'(exp ? a + 11'h040 : a + 11'h001));
    clr_fetch();
  endtask

  initial begin
    // idx5 starts at 10 after the first sequence
    vecs[0]  = '{11'h005, 1'b1, 1'b1};
    vecs[1]  = '{11'h005, 1'b1, 1'b1};
    vecs[2]  = '{11'h005, 1'b1, 1'b1};
    vecs[3]  = '{11'h015, 1'b1, 1'b1};
    vecs[4]  = '{11'h005, 1'b0, 1'b1};
    vecs[5]  = '{11'h005, 1'b0, 1'b0};
    vecs[6]  = '{11'h7F5, 1'b0, 1'b0};
    vecs[7]  = '{11'h005, 1'b0, 1'b0};
    vecs[8]  = '{11'h005, 1'b1, 1'b0};
    vecs[9]  = '{11'h005, 1'b1, 1'b1};
    vecs[10] = '{11'h009, 1'b1, 1'b1};
    vecs[11] = '{11'h006, 1'b0, 1'b0};

    clr_fetch();
    clr_res();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    check("rst_chk_valid", 32'(bus.chk_valid), 32'd0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_stat_br", 32'(stat_br), 32'd0);
    check("rst_stat_mp", 32'(stat_mp), 32'd0);

    // first fetch: weakly not-taken, one-cycle enqueue
    set_fetch(11'h005, 2'b01);
    check("t1_pred_taken", 32'(bus.predict_taken), 32'd0);
    check("t1_pred_addr", 32'(bus.predict_addr), 32'h006);
    tick();
    clr_fetch();
    check("t1_chk_valid", 32'(bus.chk_valid), 32'd1);
    check("t1_chk_type", 32'(bus.chk_branch_type), 32'd1);
    check("t1_chk_taken", 32'(bus.chk_branch_taken), 32'd0);
    check("t1_chk_baddr", 32'(bus.chk_branch_addr), 32'h006);
    check("t1_chk_jaddr", 32'(bus.chk_jump_addr), 32'h045);

    // mispredict: taken outcome, flush pulse next cycle
    resolve(1'b1, 1'b0);
    check("t2_flush", 32'(bus.flush), 32'd1);
    check("t2_chk_valid", 32'(bus.chk_valid), 32'd0);
    tick();
    check("t2_flush_end", 32'(bus.flush), 32'd0);
    probe(11'h005, 1'b1, "t2");

    // non-branch and invalid fetches never predict taken or enqueue
    set_fetch(11'h005, 2'b00);
    check("none_taken", 32'(bus.predict_taken), 32'd0);
    check("none_addr", 32'(bus.predict_addr), 32'h006);
    bus.fetch_branch_type = 2'b01;
    bus.fetch_valid = 1'b0;
    #1;
    check("invalid_taken", 32'(bus.predict_taken), 32'd0);
    bus.fetch_valid = 1'b1;
    bus.fetch_branch_type = 2'b00;
    tick();
    clr_fetch();
    check("none_no_push", 32'(bus.chk_valid), 32'd0);

    // counter training table
    for (int i = 0; i < 12; i++) begin
      push_br(vecs[i].addr, 2'b01);
      resolve(vecs[i].result, 1'b1);
      probe(vecs[i].addr, vecs[i].exp_pred, $sformatf("vec%0d", i));
    end

    // fill to full, refused 5th push, drain in order
    push_br(11'h001, 2'b01);
    push_br(11'h002, 2'b10);
    push_br(11'h003, 2'b11);
    push_br(11'h004, 2'b01);
    check("full_ready", 32'(bus.fetch_ready), 32'd0);
    check("full_chk_valid", 32'(bus.chk_valid), 32'd1);
    push_br(11'h00A, 2'b01);
    check("full_head0", 32'(bus.chk_branch_addr), 32'h002);
    resolve(1'b0, 1'b1);
    check("full_ready_after_pop", 32'(bus.fetch_ready), 32'd1);
    check("full_head1", 32'(bus.chk_branch_addr), 32'h003);
    check("full_head1_type", 32'(bus.chk_branch_type), 32'd2);
    resolve(1'b0, 1'b1);
    check("full_head2", 32'(bus.chk_branch_addr), 32'h004);
    check("full_head2_type", 32'(bus.chk_branch_type), 32'd3);
    resolve(1'b0, 1'b1);
    check("full_head3", 32'(bus.chk_branch_addr), 32'h005);
    resolve(1'b0, 1'b1);
    check("full_drained", 32'(bus.chk_valid), 32'd0);

    // same-cycle push and pop
    push_br(11'h00C, 2'b01);
    set_fetch(11'h00D, 2'b01);
    bus.res_valid = 1'b1;
    bus.prediction_success = 1'b1;
    bus.branch_result = 1'b0;
    tick();
    clr_fetch();
    clr_res();
    check("pp_chk_valid", 32'(bus.chk_valid), 32'd1);
    check("pp_head", 32'(bus.chk_branch_addr), 32'h00E);
    resolve(1'b0, 1'b1);
    check("pp_drained", 32'(bus.chk_valid), 32'd0);

    // mispredict with 3 queued and a same-cycle push
    push_br(11'h011, 2'b01);
    push_br(11'h012, 2'b01);
    push_br(11'h013, 2'b01);
    set_fetch(11'h014, 2'b01);
    bus.res_valid = 1'b1;
    bus.prediction_success = 1'b0;
    bus.branch_result = 1'b1;
    tick();
    clr_fetch();
    clr_res();
    check("mp_chk_valid", 32'(bus.chk_valid), 32'd0);
    check("mp_flush", 32'(bus.flush), 32'd1);
    check("mp_ready", 32'(bus.fetch_ready), 32'd1);
    tick();
    check("mp_flush_1cyc", 32'(bus.flush), 32'd0);
    check("mp_push_dropped", 32'(bus.chk_valid), 32'd0);

    // reset mid-traffic with a pending mispredict verdict
    push_br(11'h005, 2'b01);
    check("rs_chk_taken", 32'(bus.chk_branch_taken), 32'd1);
    check("rs_chk_jaddr", 32'(bus.chk_jump_addr), 32'h045);
    push_br(11'h021, 2'b01);
    bus.res_valid = 1'b1;
    bus.prediction_success = 1'b0;
    #2 rst_n = 1'b0;
    clr_res();
    set_fetch(11'h005, 2'b01);
    check("rs_chk_valid", 32'(bus.chk_valid), 32'd0);
    check("rs_ready", 32'(bus.fetch_ready), 32'd1);
    check("rs_idx5_cnt", 32'(bus.predict_taken), 32'd0);
    bus.fetch_addr = 11'h009;
    #1;
    check("rs_idx9_cnt", 32'(bus.predict_taken), 32'd0);
    clr_fetch();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rs_no_flush", 32'(bus.flush), 32'd0);
    check("rs_empty", 32'(bus.chk_valid), 32'd0);
    check("rs_stat_br0", 32'(stat_br), 32'd0);

    // statistics: 3 resolves, 1 mispredict
    push_br(11'h030, 2'b01);
    resolve(1'b0, 1'b1);
    push_br(11'h031, 2'b01);
    resolve(1'b1, 1'b0);
    tick();
    push_br(11'h032, 2'b01);
    resolve(1'b0, 1'b1);
`ifdef BHT_STATS_EN
    check("stat_branches", 32'(stat_br), 32'd3);
    check("stat_mispredicts", 32'(stat_mp), 32'd1);
`else
    check("stat_branches", 32'(stat_br), 32'd0);
    check("stat_mispredicts", 32'(stat_mp), 32'd0);
`endif

    // idx6 was 00 before reset; back at 01 a single taken reaches 10
    push_br(11'h006, 2'b01);
    resolve(1'b1, 1'b1);
    probe(11'h006, 1'b1, "rs_idx6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
